rbcp_reg_bank: RTL and testbench
================================

// Module: rbcp_reg_bank
// PURPOSE
//  RBCP (UDP slow-control) register slave directly downstream of the SiTCP core: consumes RBCP_ACT/ADDR/WE/WD/RE,
//  returns RBCP_ACK/RD. Holds NUM_CTRL read/write control bytes and exposes NUM_STAT read-only status bytes.
//  Emits a per-byte write strobe (control) and read strobe (status), e.g. for triggers and pop-on-read FIFOs.
//  Runs in the USRCLK domain of the TCP/IP core; no CDC inside.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000      first RBCP address decoded by this bank
//  NUM_CTRL   16                 number of R/W control bytes (1..256)
//  NUM_STAT   16                 number of read-only status bytes (0..256)
//  CTRL_INIT  {8*NUM_CTRL{1'b0}} reset value of control bytes, byte i = CTRL_INIT[8i+7:8i]
// PORTS
//  USRCLK     in   1             clock, same as the TCP/IP core user clock
//  RST        in   1             synchronous, active-high reset
//  RBCP_ACT   in   1             RBCP transaction active (frame in progress)
//  RBCP_ADDR  in   32            byte address, valid with WE/RE
//  RBCP_WE    in   1             1-cycle write pulse
//  RBCP_WD    in   8             write data, valid with WE
//  RBCP_RE    in   1             1-cycle read pulse
//  RBCP_ACK   out  1             1-cycle acknowledge
//  RBCP_RD    out  8             read data, valid only while RBCP_ACK=1
//  CTRL_REGS  out  8*NUM_CTRL    control bytes, byte i at [8i+7:8i]
//  CTRL_WSTB  out  NUM_CTRL      1-cycle pulse, bit i = byte i written (same cycle the new value appears)
//  STAT_REGS  in   8*NUM_STAT    status bytes, byte j at [8j+7:8j]
//  STAT_RSTB  out  NUM_STAT      1-cycle pulse, bit j = status byte j sampled
// BEHAVIOUR
//  - Reset: RBCP_ACK=0, RBCP_RD=8'h00, CTRL_REGS=CTRL_INIT, CTRL_WSTB=0, STAT_RSTB=0, FSM=IDLE.
//  - Decode: off = RBCP_ADDR - BASE_ADDR (32-bit unsigned, wraps); off<NUM_CTRL -> ctrl byte off;
//    NUM_CTRL<=off<NUM_CTRL+NUM_STAT -> stat byte off-NUM_CTRL; else miss. Addresses below BASE wrap -> miss.
//  - FSM IDLE/ACK. IDLE: on (WE|RE)&RBCP_ACT&hit at cycle t -> ACK at t+1. ACK: RBCP_ACK=1 one cycle -> IDLE.
//  - Write hit on ctrl byte i at t: CTRL_REGS byte i = WD and CTRL_WSTB[i]=1 at t+1; RBCP_RD=8'h00 during ACK.
//  - Write hit on stat byte: no register change, no strobe, ACK still given (write ignored).
//  - Read hit at t: ctrl byte or STAT_REGS byte sampled at t into RBCP_RD, presented at t+1 with ACK;
//    STAT_RSTB[j]=1 at t+1 for stat reads only.
//  - RBCP_RD returns to 8'h00 the cycle after ACK. Latency fixed: exactly 1 cycle, one ACK per accepted access.
//  - Miss: no ACK, no strobes, no state change (host side times out -> bus error).
//  - WE and RE in the same cycle: write wins, single ACK, RD=8'h00, no STAT_RSTB.
//  - WE/RE while FSM=ACK: ignored (SiTCP never issues back-to-back); no second ACK.
//  - WE/RE with RBCP_ACT=0: ignored.
//  - RST asserted at any time (incl. during ACK): next cycle all outputs at reset values, pending ACK dropped.
// STRUCTURE
//  - Shared package rbcp_pkg: RBCP_ADDR_W=32, RBCP_DATA_W=8, typedef rbcp_state_t {IDLE, ACK}.
//  - Single flat module; decode and FSM inline; no sub-module warranted.
// TESTING
//  - BASE=32'h100: WE @0x103 WD=A5 -> next cycle ACK=1, RD=00, CTRL byte3=A5, CTRL_WSTB=16'h0008, then all 0.
//  - RE @0x103 after above -> next cycle ACK=1, RD=A5, STAT_RSTB=0; RD=00 following cycle.
//  - STAT byte2=3C, RE @0x112 -> ACK=1, RD=3C, STAT_RSTB[2]=1; WE @0x112 WD=FF -> ACK=1, no CTRL change.
//  - RE @0x0FF and @0x120 (miss both sides) -> no ACK over 16 cycles, no strobes.
//  - WE+RE same cycle @0x101 WD=5A -> one ACK, RD=00, CTRL byte1=5A, CTRL_WSTB[1]=1, STAT_RSTB=0.
//  - WE @0x100 then RST on the ACK cycle -> ACK=0 next cycle, CTRL byte0 back to CTRL_INIT byte0.

Source files
------------

// File: rtl/rbcp_pkg.sv
// Shared RBCP bus constants and the slave handshake state type.
package rbcp_pkg;

  localparam int RBCP_ADDR_W = 32;
  localparam int RBCP_DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rbcp_state_t;

endpackage

// File: rtl/rbcp_reg_bank.sv
// RBCP slow-control register slave: NUM_CTRL R/W control bytes, NUM_STAT read-only
// status bytes, fixed 1-cycle ACK latency, per-byte write/read strobes.
module rbcp_reg_bank
  import rbcp_pkg::*;
#(
  parameter logic [RBCP_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int                     NUM_CTRL  = 16,
  parameter int                     NUM_STAT  = 16,
  parameter logic [8*NUM_CTRL-1:0]  CTRL_INIT = '0,
  localparam int                    STAT_N    = (NUM_STAT > 0) ? NUM_STAT : 1
) (
  input  logic                   USRCLK,
  input  logic                   RST,
  input  logic                   RBCP_ACT,
  input  logic [RBCP_ADDR_W-1:0] RBCP_ADDR,
  input  logic                   RBCP_WE,
  input  logic [RBCP_DATA_W-1:0] RBCP_WD,
  input  logic                   RBCP_RE,
  output logic                   RBCP_ACK,
  output logic [RBCP_DATA_W-1:0] RBCP_RD,
  output logic [8*NUM_CTRL-1:0]  CTRL_REGS,
  output logic [NUM_CTRL-1:0]    CTRL_WSTB,
  input  logic [8*STAT_N-1:0]    STAT_REGS,
  output logic [STAT_N-1:0]      STAT_RSTB
);

  rbcp_state_t            state;
  logic                   ack_p1;
  logic [RBCP_DATA_W-1:0] rd_p1;
  logic [8*NUM_CTRL-1:0]  ctrl_p1;
  logic [NUM_CTRL-1:0]    wstb_p1;
  logic [STAT_N-1:0]      rstb_p1;

  logic [RBCP_ADDR_W-1:0] off;
  logic [RBCP_ADDR_W-1:0] stat_off;
  logic                   ctrl_hit;
  logic                   stat_hit;
  logic                   accept;
  logic [RBCP_DATA_W-1:0] rd_sel;

  // Stage p0: address decode and read mux; addresses below BASE wrap to huge offsets and miss
  always_comb begin
    off      = RBCP_ADDR - BASE_ADDR;
    stat_off = off - 32'(NUM_CTRL);
    ctrl_hit = (off < 32'(NUM_CTRL));
    stat_hit = (off >= 32'(NUM_CTRL)) && (off < 32'(NUM_CTRL + NUM_STAT));
    accept   = (state == IDLE) && RBCP_ACT && (RBCP_WE || RBCP_RE) && (ctrl_hit || stat_hit);
    rd_sel   = '0;
    for (int i = 0; i < NUM_CTRL; i++)
      if (ctrl_hit && (off == 32'(i))) rd_sel = ctrl_p1[8*i +: 8];
    for (int j = 0; j < NUM_STAT; j++)
      if (stat_hit && (stat_off == 32'(j))) rd_sel = STAT_REGS[8*j +: 8];
  end

  // Stage p1: registered response; write takes priority over a simultaneous read
  always_ff @(posedge USRCLK) begin
    if (RST) begin
      state   <= IDLE;
      ack_p1  <= 1'b0;
      rd_p1   <= '0;
      ctrl_p1 <= CTRL_INIT;
      wstb_p1 <= '0;
      rstb_p1 <= '0;
    end else begin
      ack_p1  <= 1'b0;
      rd_p1   <= '0;
      wstb_p1 <= '0;
      rstb_p1 <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= ACK;
            ack_p1 <= 1'b1;
            if (RBCP_WE) begin
              for (int i = 0; i < NUM_CTRL; i++) begin
                if (ctrl_hit && (off == 32'(i))) begin
                  ctrl_p1[8*i +: 8] <= RBCP_WD;
                  wstb_p1[i]        <= 1'b1;
                end
              end
            end else begin
              rd_p1 <= rd_sel;
              for (int j = 0; j < NUM_STAT; j++)
                if (stat_hit && (stat_off == 32'(j))) rstb_p1[j] <= 1'b1;
            end
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign RBCP_ACK  = ack_p1;
  assign RBCP_RD   = rd_p1;
  assign CTRL_REGS = ctrl_p1;
  assign CTRL_WSTB = wstb_p1;
  assign STAT_RSTB = rstb_p1;

endmodule

// File: tb/tb_rbcp_reg_bank.sv
// Directed bench for rbcp_reg_bank with BASE=0x100, 16 control and 16 status bytes.
module tb_rbcp_reg_bank;

  localparam logic [31:0]  BASE = 32'h0000_0100;
  localparam logic [127:0] INIT = 128'h0000_0000_0000_0000_0000_0000_0000_0011;

  logic         clk = 1'b0;
  logic         rst;
  logic         act;
  logic [31:0]  addr;
  logic         we;
  logic [7:0]   wd;
  logic         re;
  logic         ack;
  logic [7:0]   rd;
  logic [127:0] ctrl;
  logic [15:0]  wstb;
  logic [127:0] stat;
  logic [15:0]  rstb;

  int tests  = 0;
  int failed = 0;

  logic [127:0] exp_ctrl;
  int           ack_seen;
  int           stb_seen;

  rbcp_reg_bank #(
    .BASE_ADDR(BASE),
    .NUM_CTRL (16),
    .NUM_STAT (16),
    .CTRL_INIT(INIT)
  ) dut (
    .USRCLK   (clk),
    .RST      (rst),
    .RBCP_ACT (act),
    .RBCP_ADDR(addr),
    .RBCP_WE  (we),
    .RBCP_WD  (wd),
    .RBCP_RE  (re),
    .RBCP_ACK (ack),
    .RBCP_RD  (rd),
    .CTRL_REGS(ctrl),
    .CTRL_WSTB(wstb),
    .STAT_REGS(stat),
    .STAT_RSTB(rstb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one access for a single cycle; returns #1 after the edge that sampled it.
  task automatic access(input logic a, input logic w, input logic r,
                        input logic [31:0] ad, input logic [7:0] d);
    act = a; we = w; re = r; addr = ad; wd = d;
    @(posedge clk); #1;
    act = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wd = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; act = 1'b0; addr = '0; we = 1'b0; wd = '0; re = 1'b0;
    stat = '0;
    stat[8*2 +: 8] = 8'h3C;
    stat[8*5 +: 8] = 8'h9E;
    exp_ctrl = INIT;
    repeat (3) step();

    chk("rst_ack",  {127'b0, ack}, 128'd0);
    chk("rst_rd",   {120'b0, rd},  128'd0);
    chk("rst_ctrl", ctrl,          INIT);
    chk("rst_wstb", {112'b0, wstb}, 128'd0);
    chk("rst_rstb", {112'b0, rstb}, 128'd0);
    rst = 1'b0;
    step();

    // write ctrl byte 3
    access(1'b1, 1'b1, 1'b0, 32'h103, 8'hA5);
    exp_ctrl[8*3 +: 8] = 8'hA5;
    chk("wr3_ack",  {127'b0, ack},  128'd1);
    chk("wr3_rd",   {120'b0, rd},   128'd0);
    chk("wr3_ctrl", ctrl,           exp_ctrl);
    chk("wr3_wstb", {112'b0, wstb}, 128'h0008);
    step();
    chk("wr3_ack_off",  {127'b0, ack},  128'd0);
    chk("wr3_wstb_off", {112'b0, wstb}, 128'd0);
    step();

    // read back ctrl byte 3
    access(1'b1, 1'b0, 1'b1, 32'h103, 8'h00);
    chk("rd3_ack",  {127'b0, ack},  128'd1);
    chk("rd3_rd",   {120'b0, rd},   128'hA5);
    chk("rd3_rstb", {112'b0, rstb}, 128'd0);
    step();
    chk("rd3_rd_off",  {120'b0, rd},  128'd0);
    chk("rd3_ack_off", {127'b0, ack}, 128'd0);
    step();

    // read status byte 2 and byte 5
    access(1'b1, 1'b0, 1'b1, 32'h112, 8'h00);
    chk("st2_ack",  {127'b0, ack},  128'd1);
    chk("st2_rd",   {120'b0, rd},   128'h3C);
    chk("st2_rstb", {112'b0, rstb}, 128'h0004);
    step();
    chk("st2_rstb_off", {112'b0, rstb}, 128'd0);
    step();
    access(1'b1, 1'b0, 1'b1, 32'h115, 8'h00);
    chk("st5_rd",   {120'b0, rd},   128'h9E);
    chk("st5_rstb", {112'b0, rstb}, 128'h0020);
    step();
    step();

    // write to a status byte is acknowledged but ignored
    access(1'b1, 1'b1, 1'b0, 32'h112, 8'hFF);
    chk("wst_ack",  {127'b0, ack},  128'd1);
    chk("wst_ctrl", ctrl,           exp_ctrl);
    chk("wst_wstb", {112'b0, wstb}, 128'd0);
    chk("wst_rstb", {112'b0, rstb}, 128'd0);
    step();
    step();

    // misses below and above the decoded window
    ack_seen = 0; stb_seen = 0;
    act = 1'b1; re = 1'b1; addr = 32'h0FF;
    @(posedge clk); #1;
    re = 1'b0; addr = '0;
    step();
    re = 1'b1; we = 1'b1; addr = 32'h120; wd = 8'h77;
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0; act = 1'b0; addr = '0; wd = '0;
    for (int k = 0; k < 16; k++) begin
      if (ack) ack_seen++;
      if ((wstb != 16'h0) || (rstb != 16'h0)) stb_seen++;
      step();
    end
    chk("miss_ack",  ack_seen, 128'd0);
    chk("miss_stb",  stb_seen, 128'd0);
    chk("miss_ctrl", ctrl,     exp_ctrl);

    // access with ACT low is ignored
    access(1'b0, 1'b1, 1'b0, 32'h105, 8'h42);
    chk("noact_ack",  {127'b0, ack}, 128'd0);
    chk("noact_ctrl", ctrl,          exp_ctrl);
    step();

    // simultaneous WE+RE: write wins
    access(1'b1, 1'b1, 1'b1, 32'h101, 8'h5A);
    exp_ctrl[8*1 +: 8] = 8'h5A;
    chk("wr_rd_ack",  {127'b0, ack},  128'd1);
    chk("wr_rd_rd",   {120'b0, rd},   128'd0);
    chk("wr_rd_ctrl", ctrl,           exp_ctrl);
    chk("wr_rd_wstb", {112'b0, wstb}, 128'h0002);
    chk("wr_rd_rstb", {112'b0, rstb}, 128'd0);
    step();
    chk("wr_rd_single_ack", {127'b0, ack}, 128'd0);
    step();

    // second write issued during ACK is dropped
    access(1'b1, 1'b1, 1'b0, 32'h104, 8'h66);
    exp_ctrl[8*4 +: 8] = 8'h66;
    chk("bb_first_ack", {127'b0, ack}, 128'd1);
    access(1'b1, 1'b1, 1'b0, 32'h106, 8'h99);
    chk("bb_second_ack", {127'b0, ack},  128'd0);
    chk("bb_ctrl",       ctrl,           exp_ctrl);
    chk("bb_wstb",       {112'b0, wstb}, 128'd0);
    step();

    // reset on the ACK cycle drops the ACK and restores CTRL_INIT
    access(1'b1, 1'b1, 1'b0, 32'h100, 8'h77);
    exp_ctrl[8*0 +: 8] = 8'h77;
    chk("rstack_ack",  {127'b0, ack}, 128'd1);
    chk("rstack_ctrl", ctrl,          exp_ctrl);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstack_ack_drop", {127'b0, ack},  128'd0);
    chk("rstack_ctrl_init", ctrl,          INIT);
    chk("rstack_wstb",     {112'b0, wstb}, 128'd0);
    step();
    chk("rstack_no_late_ack", {127'b0, ack}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
